aer_spike_collector: RTL and testbench

Receiving end of the first-layer AER spike stream. Consumes the per-step spike/address pulses and step-finished strobes emitted by a spike generation unit, keeps one spike counter per output neuron address over a fixed window of time steps, then scans the counters for the winning neuron. It presents the class and its count on a valid/ready result port, clearing the counters during the scan so the next window starts from zero.

---
 rtl/aer_spike_collector.sv | 176 +++++++++++++++++
 tb/tb_aer_spike_collector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_collector.sv
// rtl/aer_spike_collector.sv - AER spike counter window with argmax scan and valid/ready result
//
// Purpose:
//    Counts spikes per neuron address over NUM_STEPS time steps, then scans
//    the counters one address per cycle to find the winner. Each counter is
//    cleared as it is scanned, so the next window starts from zero. The
//    winner is presented on a valid/ready result port.
//
// Optional feature macro: AER_COUNT_SAT_EN
//    defined   - counters saturate at 2^CNT_W-1 (extra spikes silently discarded)
//    undefined - counters wrap modulo 2^CNT_W
//
// Ports:
//    clk            in   system clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    spike_in       in   spike strobe
//    spike_AER      in   [5:0] address of spiking neuron
//    step_finished  in   one-cycle strobe, time step done
//    result_ready   in   downstream accepts result
//    result_valid   out  result_class/result_count valid
//    result_class   out  [5:0] winning neuron address
//    result_count   out  [CNT_W-1:0] winning spike count
//    busy           out  high outside COLLECT (inputs ignored)
//    drop_err       out  sticky: spike dropped or address out of range

module aer_spike_collector #(
   parameter int NUM_NEURONS = 40,
   parameter int NUM_STEPS   = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spike_in,
   input  logic [5:0]       spike_AER,
   input  logic             step_finished,
   input  logic             result_ready,
   output logic             result_valid,
   output logic [5:0]       result_class,
   output logic [CNT_W-1:0] result_count,
   output logic             busy,
   output logic             drop_err
);

   localparam int          STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
   localparam logic [5:0]  LAST_IDX  = 6'(NUM_NEURONS - 1);
   localparam logic [6:0]  ADDR_LIM  = 7'(NUM_NEURONS);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SCAN    = 2'd1,
      RESULT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [5:0]        idx_q, idx_d;
   logic [5:0]        best_cls_q, best_cls_d;
   logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
   logic              valid_q, valid_d;
   logic              drop_q, drop_d;

   logic [CNT_W-1:0]  cnt_q [NUM_NEURONS];

   logic              addr_ok;
   logic              cnt_inc;
   logic              cnt_clr;
   logic [CNT_W-1:0]  cnt_cur;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  scan_val;

   assign addr_ok  = ({1'b0, spike_AER} < ADDR_LIM);
   assign cnt_cur  = addr_ok ? cnt_q[spike_AER] : '0;
   assign scan_val = cnt_q[idx_q];

`ifdef AER_COUNT_SAT_EN
   assign cnt_nxt = (cnt_cur == {CNT_W{1'b1}}) ? cnt_cur : cnt_cur + CNT_W'(1);
`else
   assign cnt_nxt = cnt_cur + CNT_W'(1);
`endif

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      idx_d      = idx_q;
      best_cls_d = best_cls_q;
      best_cnt_d = best_cnt_q;
      valid_d    = valid_q;
      drop_d     = drop_q;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;

      unique case (state_q)
         COLLECT: begin
            // A spike that coincides with the final step strobe still belongs
            // to this window: the increment lands on the same edge as the
            // move to SCAN, before idx reaches its address.
            if (spike_in) begin
               if (addr_ok) cnt_inc = 1'b1;
               else         drop_d  = 1'b1;
            end
            if (step_finished) begin
               if (step_q == LAST_STEP) begin
                  state_d    = SCAN;
                  step_d     = '0;
                  idx_d      = '0;
                  best_cls_d = '0;
                  best_cnt_d = '0;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         SCAN: begin
            if (spike_in) drop_d = 1'b1;
            cnt_clr = 1'b1;
            // Strict compare keeps the lowest address on ties.
            if (scan_val > best_cnt_q) begin
               best_cnt_d = scan_val;
               best_cls_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = RESULT;
               valid_d = 1'b1;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         RESULT: begin
            if (spike_in) drop_d = 1'b1;
            if (valid_q && result_ready) begin
               valid_d = 1'b0;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         step_q     <= '0;
         idx_q      <= '0;
         best_cls_q <= '0;
         best_cnt_q <= '0;
         valid_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         idx_q      <= idx_d;
         best_cls_q <= best_cls_d;
         best_cnt_q <= best_cnt_d;
         valid_q    <= valid_d;
         drop_q     <= drop_d;
      end
   end

   // cnt_inc and cnt_clr belong to different states, never both set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
      end else begin
         if (cnt_clr) cnt_q[idx_q]     <= '0;
         if (cnt_inc) cnt_q[spike_AER] <= cnt_nxt;
      end
   end

   assign result_valid = valid_q;
   assign result_class = best_cls_q;
   assign result_count = best_cnt_q;
   assign busy         = (state_q != COLLECT);
   assign drop_err     = drop_q;

endmodule

// File: tb/tb_aer_spike_collector.sv
// tb/tb_aer_spike_collector.sv - directed self-checking bench for aer_spike_collector

module tb_aer_spike_collector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spike_in;
   logic [5:0] spike_AER;
   logic       step_finished;
   logic       result_ready;

   logic       result_valid, s_valid;
   logic [5:0] result_class, s_class;
   logic [7:0] result_count;
   logic [3:0] s_count;
   logic       busy, s_busy;
   logic       drop_err, s_drop;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   aer_spike_collector #(.NUM_NEURONS(40), .NUM_STEPS(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_AER(spike_AER),
      .step_finished(step_finished), .result_ready(result_ready),
      .result_valid(result_valid), .result_class(result_class),
      .result_count(result_count), .busy(busy), .drop_err(drop_err)
   );

   aer_spike_collector #(.NUM_NEURONS(40), .NUM_STEPS(4), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_AER(spike_AER),
      .step_finished(step_finished), .result_ready(result_ready),
      .result_valid(s_valid), .result_class(s_class),
      .result_count(s_count), .busy(s_busy), .drop_err(s_drop)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic spikes(input logic [5:0] addr, input int n);
      for (int i = 0; i < n; i++) begin
         spike_in  = 1'b1;
         spike_AER = addr;
         tick();
         spike_in  = 1'b0;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         step_finished = 1'b1;
         tick();
         step_finished = 1'b0;
      end
   endtask

   // Final step strobe (optionally with a spike), then wait for the result.
   task automatic final_step(input logic sp, input logic [5:0] addr,
                             input int exp_class, input int exp_count);
      int lat;
      spike_in      = sp;
      spike_AER     = addr;
      step_finished = 1'b1;
      tick();
      spike_in      = 1'b0;
      step_finished = 1'b0;
      check("busy_after_final", busy, 1);
      lat = 0;
      while (!result_valid && lat < 200) begin
         tick();
         lat++;
      end
      check("latency", lat, 40);
      check("class", result_class, exp_class);
      check("count", result_count, exp_count);
      if (result_ready) begin
         tick();
         check("valid_after_hs", result_valid, 0);
         check("busy_after_hs", busy, 0);
      end
   endtask

   initial begin
      logic       stable;
      logic [5:0] hold_class;
      logic [7:0] hold_count;

      rst_n         = 1'b0;
      spike_in      = 1'b0;
      spike_AER     = '0;
      step_finished = 1'b0;
      result_ready  = 1'b1;
      tick();
      tick();
      check("rst_valid", result_valid, 0);
      check("rst_class", result_class, 0);
      check("rst_count", result_count, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_err, 0);
      rst_n = 1'b1;
      tick();

      // Window A: addr 7 x5, addr 3 x2
      spikes(6'd7, 3);
      steps(1);
      spikes(6'd3, 2);
      spikes(6'd7, 2);
      steps(2);
      final_step(1'b0, 6'd0, 7, 5);
      check("drop_clean", drop_err, 0);

      // Empty window: counters must have been cleared by the scan
      steps(3);
      final_step(1'b0, 6'd0, 0, 0);

      // Tie: lowest address wins
      spikes(6'd30, 3);
      steps(1);
      spikes(6'd12, 3);
      steps(2);
      final_step(1'b0, 6'd0, 12, 3);

      // Out-of-range address, spike on final step edge
      spikes(6'd45, 1);
      check("drop_oor", drop_err, 1);
      steps(3);
      final_step(1'b1, 6'd2, 2, 1);

      // Reset while scanning idx 10
      spikes(6'd20, 3);
      steps(3);
      step_finished = 1'b1;
      tick();
      step_finished = 1'b0;
      repeat (10) tick();
      check("scan_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mrst_valid", result_valid, 0);
      check("mrst_class", result_class, 0);
      check("mrst_count", result_count, 0);
      check("mrst_busy", busy, 0);
      check("mrst_drop", drop_err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      spikes(6'd1, 2);
      steps(3);
      final_step(1'b0, 6'd0, 1, 2);

      // Backpressure with spikes during RESULT
      result_ready = 1'b0;
      spikes(6'd9, 2);
      steps(3);
      final_step(1'b0, 6'd0, 9, 2);
      hold_class = result_class;
      hold_count = result_count;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         spike_in  = 1'b1;
         spike_AER = 6'd9;
         tick();
         if (!result_valid || result_class != hold_class || result_count != hold_count)
            stable = 1'b0;
      end
      spike_in = 1'b0;
      check("bp_stable", stable, 1);
      check("bp_drop", drop_err, 1);
      result_ready = 1'b1;
      tick();
      check("bp_valid_after_hs", result_valid, 0);
      check("bp_busy_after_hs", busy, 0);
      spikes(6'd9, 1);
      steps(3);
      final_step(1'b0, 6'd0, 9, 1);

      // 20 spikes to addr 5: 8-bit counts 20; 4-bit saturates or wraps
      spikes(6'd5, 20);
      steps(3);
      spike_in      = 1'b0;
      step_finished = 1'b1;
      tick();
      step_finished = 1'b0;
      repeat (40) tick();
      check("sat_valid", result_valid, 1);
      check("sat_small_valid", s_valid, 1);
      check("sat_class", result_class, 5);
      check("sat_count", result_count, 20);
      check("sat_small_class", s_class, 5);
`ifdef AER_COUNT_SAT_EN
      check("sat_small_count", s_count, 15);
`else
      check("wrap_small_count", s_count, 4);
`endif
      tick();
      check("sat_busy_after_hs", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
